ifetch_buf: RTL and testbench
=============================

Name: ifetch_buf

Overview:
- Instruction fetch buffer placed directly upstream of the microprocessor's `ins` input.
- Fetches sequential 16-bit instruction words from a variable-latency instruction memory using a req/ack handshake.
- Holds prefetched words in a small FIFO and presents the head word, with its address, to the processor on demand.
- Supports a redirect (jump) that flushes the buffer and restarts fetching at a new address.

Parameters:
- DEPTH, 4: FIFO entries; power of two, minimum 2.
- AW, 16: instruction address width.
- DW, 16: instruction word width.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- redirect  in  1  flush the buffer and restart fetch at redirect_addr.
- redirect_addr  in  AW  new fetch address, sampled when redirect=1.
- mem_req  out  1  memory request; held high until acknowledged.
- mem_addr  out  AW  request address; stable while mem_req=1.
- mem_ack  in  1  memory completion; mem_data is valid in the same cycle.
- mem_data  in  DW  instruction word returned by memory.
- ins_valid  out  1  FIFO head is valid.
- ins  out  DW  FIFO head instruction.
- ins_pc  out  AW  address of the FIFO head instruction.
- ins_take  in  1  consumer pops the head; ignored when ins_valid=0.

Behaviour:
- Reset (asynchronous):
  - fetch_pc=0, req_addr=0, count=0, state=IDLE.
  - mem_req=0, mem_addr=0, ins_valid=0, ins=0, ins_pc=0.
  - Reset during an outstanding request abandons it; memory must tolerate mem_req dropping without an ack.
- State machine, registered:
  - IDLE:
    - If count<DEPTH and redirect=0: req_addr<=fetch_pc, go to WAIT.
    - Otherwise stay in IDLE.
  - WAIT:
    - mem_ack=1, redirect=0: push {req_addr, mem_data}; fetch_pc<=fetch_pc+1; go to IDLE.
    - mem_ack=1, redirect=1: discard the returned data; fetch_pc<=redirect_addr; go to IDLE.
    - mem_ack=0, redirect=1: fetch_pc<=redirect_addr; go to DROP.
    - mem_ack=0, redirect=0: stay in WAIT.
  - DROP (stale request in flight):
    - mem_ack=1: discard the data; go to IDLE.
    - redirect=1 while in DROP: update fetch_pc only; remain in DROP unless mem_ack=1.
- Outputs and handshake:
  - mem_req=1 exactly when state is WAIT or DROP; mem_addr=req_addr.
  - mem_ack is sampled only while mem_req=1; ack while idle is ignored.
- Fetch ordering:
  - At most one outstanding request.
  - A request is issued only when count<DEPTH, so a push never overflows.
- Address arithmetic:
  - fetch_pc increments modulo 2^AW; 16'hFFFF wraps to 16'h0000.
- FIFO:
  - ins_valid=(count!=0); ins and ins_pc come straight from the head entry (no extra latency).
  - Pop when ins_valid and ins_take.
  - Push and pop in the same cycle leave count unchanged.
  - A pop at count=DEPTH frees a slot; the next IDLE cycle may issue a request.
- Redirect:
  - Priority over take and push in the same cycle.
  - count<=0; head and tail pointers reset; ins_valid=0 on the next cycle.
- Latency:
  - First request is issued 1 cycle after reset release.
  - With zero-wait memory (ack in the request cycle), the word is visible at ins 1 cycle after the ack.
  - Sustained throughput is 1 word per 2 cycles.
- Full case: with count=DEPTH and no take, stay in IDLE with mem_req=0 indefinitely.

Decomposition:
- Shared package ifb_pkg:
  - fetch-state enum {IDLE, WAIT, DROP};
  - DEPTH, AW and DW default constants;
  - pointer width localparam $clog2(DEPTH).
- One sub-module, ifb_fifo:
  - DEPTH x (AW+DW) storage;
  - head/tail pointers and count;
  - push, pop and flush inputs; head-data output.
- The FSM, fetch_pc and req_addr live in ifetch_buf.

Test Plan:
- Reset, zero-wait memory returning mem_data=addr^16'hA5A5, ins_take=1 always -> ins_pc sequence 0,1,2,3 with ins=A5A5,A5A4,A5A7,A5A6; one word every 2 cycles.
- ins_take=0, memory always acks -> exactly 4 pushes; mem_req stays 0 with count=4. A single take -> one new request, addr=4.
- Memory ack delayed 5 cycles, redirect to 16'h0100 at cycle 2 of the wait -> mem_req held until the ack, stale data not pushed; next request addr=16'h0100; first ins_pc=16'h0100.
- redirect_addr=16'hFFFE, zero-wait memory -> ins_pc sequence FFFE, FFFF, 0000, 0001.
- Reset asserted mid-WAIT with count=2 -> all outputs 0 immediately (asynchronous); after release, first request addr=0.
- Push and take in the same cycle at count=2 -> count stays 2; head advances by one; order preserved.

Source files
------------

// File: rtl/ifb_pkg.sv
// Shared types and default sizes for the instruction fetch buffer.
package ifb_pkg;

   localparam int unsigned DEPTH_DEF = 4;
   localparam int unsigned AW_DEF    = 16;
   localparam int unsigned DW_DEF    = 16;

   // Fetch sequencer states: idle, request outstanding, stale request outstanding.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DROP = 2'd2
   } fetch_state_t;

   // Pointer width for a FIFO of the given depth (depth is a power of two, >= 2).
   function automatic int unsigned ptr_width(input int unsigned depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/ifb_fifo.sv
// Small FIFO holding {address, instruction} pairs with a zero-latency head output.
module ifb_fifo
   import ifb_pkg::*;
#(
   parameter int unsigned DEPTH = DEPTH_DEF,
   parameter int unsigned W     = AW_DEF + DW_DEF
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           push,
   input  logic                           pop,
   input  logic                           flush,
   input  logic [W-1:0]                   wdata,
   output logic [W-1:0]                   rdata,
   output logic [ptr_width(DEPTH):0]      count
);

   localparam int unsigned PW = ptr_width(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic          do_push;
   logic          do_pop;

   // Qualify pop by occupancy; a push is allowed at full only alongside a pop.
   always_comb begin
      do_pop  = pop && (count != '0);
      do_push = push && ((count != CW'(DEPTH)) || do_pop);
   end

   // Entry storage; contents are don't-care until pushed.
   always_ff @(posedge clk) begin
      if (do_push && !flush) begin
         mem[tail] <= wdata;
      end
   end

   // Pointer and occupancy tracking; flush empties the FIFO ahead of push/pop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (do_push) begin
            tail <= tail + PW'(1);
         end
         if (do_pop) begin
            head <= head + PW'(1);
         end
         if (do_push && !do_pop) begin
            count <= count + CW'(1);
         end else if (do_pop && !do_push) begin
            count <= count - CW'(1);
         end
      end
   end

   // Head entry, forced to zero while empty so the output never shows stale data.
   assign rdata = (count != '0) ? mem[head] : '0;

endmodule

// File: rtl/ifetch_buf.sv
// Instruction fetch buffer: sequential prefetch over a req/ack memory port into a FIFO.
module ifetch_buf
   import ifb_pkg::*;
#(
   parameter int unsigned DEPTH = DEPTH_DEF,
   parameter int unsigned AW    = AW_DEF,
   parameter int unsigned DW    = DW_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          redirect,
   input  logic [AW-1:0] redirect_addr,
   output logic          mem_req,
   output logic [AW-1:0] mem_addr,
   input  logic          mem_ack,
   input  logic [DW-1:0] mem_data,
   output logic          ins_valid,
   output logic [DW-1:0] ins,
   output logic [AW-1:0] ins_pc,
   input  logic          ins_take
);

   localparam int unsigned CW = ptr_width(DEPTH) + 1;

   fetch_state_t     state;
   fetch_state_t     state_nxt;
   logic [AW-1:0]    fetch_pc;
   logic [AW-1:0]    req_addr;
   logic [CW-1:0]    count;
   logic [AW+DW-1:0] head_entry;
   logic             room;
   logic             issue;
   logic             push;
   logic             advance;

   assign room = (count < CW'(DEPTH));

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; an ack always ends the outstanding request.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (room && !redirect) begin
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (mem_ack) begin
               state_nxt = IDLE;
            end else if (redirect) begin
               state_nxt = DROP;
            end
         end
         DROP: begin
            if (mem_ack) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Control decode: issue a request, or accept returned data unless redirected.
   always_comb begin
      issue   = 1'b0;
      push    = 1'b0;
      advance = 1'b0;
      case (state)
         IDLE: issue = room && !redirect;
         WAIT: begin
            push    = mem_ack && !redirect;
            advance = mem_ack && !redirect;
         end
         default: ;
      endcase
   end

   // Fetch address, latched request address and registered request strobe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc <= '0;
         req_addr <= '0;
         mem_req  <= 1'b0;
      end else begin
         if (redirect) begin
            fetch_pc <= redirect_addr;
         end else if (advance) begin
            fetch_pc <= fetch_pc + AW'(1);
         end
         if (issue) begin
            req_addr <= fetch_pc;
         end
         mem_req <= (state_nxt != IDLE);
      end
   end

   assign mem_addr = req_addr;

   ifb_fifo #(
      .DEPTH (DEPTH),
      .W     (AW + DW)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (ins_take),
      .flush (redirect),
      .wdata ({req_addr, mem_data}),
      .rdata (head_entry),
      .count (count)
   );

   assign ins_valid = (count != '0);
   assign ins       = head_entry[DW-1:0];
   assign ins_pc    = head_entry[AW+DW-1:DW];

endmodule

// File: tb/tb_ifetch_buf.sv
// Scoreboard bench for ifetch_buf: randomized memory latency, takes and redirects.
module tb_ifetch_buf;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        redirect = 1'b0;
   logic [15:0] redirect_addr = '0;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_ack = 1'b0;
   logic [15:0] mem_data = '0;
   logic        ins_valid;
   logic [15:0] ins;
   logic [15:0] ins_pc;
   logic        ins_take = 1'b0;

   always #5 clk = ~clk;

   ifetch_buf #(.DEPTH(DEPTH), .AW(16), .DW(16)) dut (
      .clk           (clk),
      .reset         (reset),
      .redirect      (redirect),
      .redirect_addr (redirect_addr),
      .mem_req       (mem_req),
      .mem_addr      (mem_addr),
      .mem_ack       (mem_ack),
      .mem_data      (mem_data),
      .ins_valid     (ins_valid),
      .ins           (ins),
      .ins_pc        (ins_pc),
      .ins_take      (ins_take)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Expected instruction stream: consecutive addresses from the last restart point.
   logic [15:0] exp_q[$];

   task automatic refill(input logic [15:0] start);
      exp_q.delete();
      for (int i = 0; i < 600; i++) exp_q.push_back(start + 16'(i));
   endtask

   // Reference model state (spec level: words buffered, next fetch address, stale request).
   int          occ = 0;
   int          prev_occ = 0;
   logic [15:0] mfetch = '0;
   logic [15:0] held_addr = '0;
   logic        stale = 1'b0;
   logic        prev_req = 1'b0;
   logic        prev_redir = 1'b0;
   int          accepts = 0;
   int          pops = 0;

   // Monitor: compares DUT outputs mid-cycle and advances the model by this cycle's events.
   always @(negedge clk) begin
      if (reset) begin
         occ = 0; prev_occ = 0; mfetch = '0; stale = 1'b0;
         prev_req = 1'b0; prev_redir = 1'b0;
      end else begin
         logic [15:0] pc;
         check("ins_valid", ins_valid, (occ != 0));
         if (occ == DEPTH) check("full_no_req", mem_req, 1'b0);
         if (mem_req && !prev_req) begin
            check("req_addr", mem_addr, mfetch);
            check("req_allowed", mem_req, (prev_occ < DEPTH) && !prev_redir);
         end
         if (mem_req && prev_req) check("addr_stable", mem_addr, held_addr);
         if (occ != 0 && ins_take && !redirect) begin
            pops++;
            if (exp_q.size() == 0) begin
               check("stream_underrun", ins_pc, 16'hXXXX);
            end else begin
               pc = exp_q.pop_front();
               check("ins_pc", ins_pc, pc);
               check("ins", ins, pc ^ 16'hA5A5);
            end
         end
         prev_occ   = occ;
         prev_req   = mem_req;
         held_addr  = mem_addr;
         prev_redir = redirect;
         if (redirect) begin
            occ    = 0;
            mfetch = redirect_addr;
            if (mem_req && !mem_ack) stale = 1'b1;
            else if (mem_req && mem_ack) stale = 1'b0;
         end else begin
            if (mem_req && mem_ack) begin
               if (stale) begin
                  stale = 1'b0;
               end else begin
                  occ++;
                  mfetch = mfetch + 16'd1;
                  accepts++;
               end
            end
            if (occ != 0 && ins_take && prev_occ != 0) occ--;
         end
      end
   end

   // Memory model state.
   logic busy = 1'b0;
   int   cnt = 0;
   int   lat = 0;
   int   force_lat = 0;
   logic idle_noise = 1'b0;

   // Advance one cycle and drive the memory response for the new cycle.
   task automatic step();
      @(posedge clk);
      #1;
      if (mem_req) begin
         if (!busy) begin
            busy = 1'b1;
            cnt  = 0;
            lat  = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
         end
         if (cnt == lat) begin
            mem_ack  = 1'b1;
            mem_data = mem_addr ^ 16'hA5A5;
            busy     = 1'b0;
         end else begin
            mem_ack  = 1'b0;
            mem_data = 16'($urandom);
            cnt++;
         end
      end else begin
         busy = 1'b0;
         if (idle_noise) begin
            mem_ack  = 1'($urandom_range(0, 1));
            mem_data = 16'($urandom);
         end else begin
            mem_ack = 1'b0;
         end
      end
   endtask

   task automatic redirect_pulse(input logic [15:0] addr);
      step();
      redirect      = 1'b1;
      redirect_addr = addr;
      refill(addr);
      step();
      redirect = 1'b0;
   endtask

   task automatic wait_req(input logic level, input string name);
      int n = 0;
      while (mem_req !== level && n < 40) begin
         step();
         n++;
      end
      check(name, mem_req, level);
   endtask

   task automatic wait_accepts(input int base, input int num, input string name);
      int n = 0;
      while (accepts - base < num && n < 40) begin
         step();
         n++;
      end
      check(name, 32'(accepts - base), 32'(num));
   endtask

   initial begin
      int p0;
      int a0;
      refill(16'h0000);

      // Reset values.
      repeat (3) step();
      check("rst_mem_req", mem_req, 1'b0);
      check("rst_mem_addr", mem_addr, 16'h0);
      check("rst_ins_valid", ins_valid, 1'b0);
      check("rst_ins", ins, 16'h0);
      check("rst_ins_pc", ins_pc, 16'h0);

      // Zero-wait streaming from address 0, always taking.
      reset     = 1'b0;
      ins_take  = 1'b1;
      force_lat = 0;
      step();
      check("first_req", mem_req, 1'b1);
      check("first_addr", mem_addr, 16'h0000);
      repeat (4) step();
      p0 = pops;
      repeat (16) step();
      check("throughput", 32'(pops - p0), 32'd8);

      // Fill to full with no takes, then one take releases exactly one request.
      ins_take = 1'b0;
      redirect_pulse(16'h0000);
      a0 = accepts;
      repeat (20) step();
      check("fill_count", 32'(accepts - a0), 32'd4);
      check("full_req_low", mem_req, 1'b0);
      check("full_valid", ins_valid, 1'b1);
      check("full_head", ins_pc, 16'h0000);
      step();
      ins_take = 1'b1;
      step();
      ins_take = 1'b0;
      wait_req(1'b1, "refill_req");
      check("refill_addr", mem_addr, 16'h0004);

      // Slow memory; redirect during the wait leaves the stale request outstanding.
      force_lat = 5;
      ins_take  = 1'b1;
      wait_req(1'b0, "slow_idle");
      wait_req(1'b1, "slow_req");
      step();
      redirect      = 1'b1;
      redirect_addr = 16'h0100;
      refill(16'h0100);
      step();
      redirect = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (mem_ack) break;
         check("drop_req_held", mem_req, 1'b1);
         step();
      end
      check("drop_ack_bound", mem_req & mem_ack, 1'b1);
      force_lat = 0;
      wait_req(1'b0, "drop_done");
      wait_req(1'b1, "post_redir_req");
      check("post_redir_addr", mem_addr, 16'h0100);
      step();
      check("post_redir_valid", ins_valid, 1'b1);
      check("post_redir_pc", ins_pc, 16'h0100);

      // Address wrap.
      p0 = pops;
      redirect_pulse(16'hFFFE);
      repeat (12) step();
      check("wrap_progress", 32'(pops - p0 >= 4), 32'd1);

      // Asynchronous reset in the middle of a wait with two words buffered.
      ins_take = 1'b0;
      redirect_pulse(16'h0040);
      a0 = accepts;
      wait_accepts(a0, 2, "pre_reset_fill");
      force_lat = 20;
      step();
      check("pre_reset_req", mem_req, 1'b1);
      #2;
      reset = 1'b1;
      #1;
      check("async_mem_req", mem_req, 1'b0);
      check("async_mem_addr", mem_addr, 16'h0);
      check("async_ins_valid", ins_valid, 1'b0);
      check("async_ins", ins, 16'h0);
      check("async_ins_pc", ins_pc, 16'h0);
      refill(16'h0000);
      repeat (2) step();
      reset     = 1'b0;
      force_lat = 0;
      ins_take  = 1'b1;
      step();
      check("rerst_req", mem_req, 1'b1);
      check("rerst_addr", mem_addr, 16'h0000);

      // Push and take in the same cycle at two words buffered.
      ins_take = 1'b0;
      redirect_pulse(16'h0200);
      a0 = accepts;
      wait_accepts(a0, 2, "pp_fill");
      step();
      check("pp_req", mem_req, 1'b1);
      ins_take = 1'b1;
      step();
      ins_take = 1'b0;
      check("pp_valid", ins_valid, 1'b1);
      check("pp_head", ins_pc, 16'h0201);
      repeat (10) step();
      check("pp_total_push", 32'(accepts - a0), 32'd5);
      check("pp_full_req", mem_req, 1'b0);

      // Randomized traffic.
      force_lat  = -1;
      idle_noise = 1'b1;
      for (int i = 0; i < 1500; i++) begin
         int take_pct;
         take_pct = ((i / 100) % 3 == 0) ? 20 : 70;
         step();
         ins_take = ($urandom_range(0, 99) < take_pct);
         if ($urandom_range(0, 24) == 0) begin
            logic [15:0] a;
            a = ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'hFFFC + 16'($urandom_range(0, 3));
            redirect      = 1'b1;
            redirect_addr = a;
            refill(a);
         end else begin
            redirect = 1'b0;
         end
      end
      idle_noise = 1'b0;
      redirect   = 1'b0;
      ins_take   = 1'b1;
      repeat (20) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Run-time bound.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

endmodule
